// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one fetch at a time to instruction
// memory, holds the returned word for decode, and redirects the program
// counter when execute resolves a taken branch.
module fetch_sequencer #(
    parameter int                 ADDR_W   = 25,
    parameter int                 INS_W    = 25,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INS_W-1:0]  mem_rdata,
    output logic              ins_valid,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              ins_ready,
    input  logic              br_valid,
    input  logic              branch,
    input  logic              zero,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] ext,
    output logic              redirect
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [INS_W-1:0]     r_ins;
    logic [ADDR_W-1:0]    r_ins_pc;
    logic                 r_ins_valid;
    logic                 r_redirect;

    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    w_pc_nxt;
    logic                 w_ins_valid_nxt;
    logic                 w_capture;
    logic                 w_taken;
    logic [ADDR_W-1:0]    w_target;
    logic [ADDR_W-1:0]    w_pc_inc;

    // Branch resolution; ext is two's complement so plain modulo addition
    // gives the signed displacement.
    assign w_taken  = br_valid & branch & zero;
    assign w_target = br_pc + ADDR_W'(1) + ext;
    assign w_pc_inc = r_pc + ADDR_W'(1);

    // A pending redirect suppresses the request so the stale pc is never fetched.
    assign mem_req   = (r_state == REQ) & ~halt & ~w_taken;
    assign mem_addr  = r_pc;
    assign ins_valid = r_ins_valid;
    assign ins       = r_ins;
    assign ins_pc    = r_ins_pc;
    assign redirect  = r_redirect;

    // Next-state, next-pc and capture decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_ins_valid_nxt = r_ins_valid;
        w_capture       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_taken)    w_pc_nxt    = w_target;
                else if (!halt) w_state_nxt = REQ;
            end
            REQ: begin
                if (w_taken)      w_pc_nxt    = w_target;
                else if (mem_req) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_taken) begin
                    // The in-flight word belongs to the wrong path; if it has
                    // not arrived yet it must still be absorbed in DRAIN.
                    w_pc_nxt    = w_target;
                    w_state_nxt = mem_ack ? REQ : DRAIN;
                end else if (mem_ack) begin
                    w_capture       = 1'b1;
                    w_ins_valid_nxt = 1'b1;
                    w_state_nxt     = HOLD;
                end
            end
            DRAIN: begin
                if (w_taken) w_pc_nxt    = w_target;
                if (mem_ack) w_state_nxt = halt ? IDLE : REQ;
            end
            HOLD: begin
                if (w_taken) begin
                    w_ins_valid_nxt = 1'b0;
                    w_pc_nxt        = w_target;
                    w_state_nxt     = REQ;
                end else if (ins_ready) begin
                    w_ins_valid_nxt = 1'b0;
                    w_pc_nxt        = w_pc_inc;
                    w_state_nxt     = halt ? IDLE : REQ;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_ins_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pc, held instruction and redirect pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_ins       <= '0;
            r_ins_pc    <= '0;
            r_ins_valid <= 1'b0;
            r_redirect  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_ins_valid <= w_ins_valid_nxt;
            r_redirect  <= w_taken;
            if (w_capture) begin
                r_ins    <= mem_rdata;
                r_ins_pc <= r_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a memory responder model returns a word derived
// from the address after a programmable delay; expected deliveries are queued
// when a request that should complete is seen and popped at each handshake.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam int AW = 25;
    localparam int IW = 25;

    logic          clk;
    logic          rst_n;
    logic          halt;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_rdata;
    logic          ins_valid;
    logic [IW-1:0] ins;
    logic [AW-1:0] ins_pc;
    logic          ins_ready;
    logic          br_valid;
    logic          branch;
    logic          zero;
    logic [AW-1:0] br_pc;
    logic [AW-1:0] ext;
    logic          redirect;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] ins;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    int            n_vec = 0;
    int            n_err = 0;
    int            ack_dly = 2;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] held_pc;
    logic [IW-1:0] held_ins;
    bit            got;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .ins_ready(ins_ready),
        .br_valid(br_valid), .branch(branch), .zero(zero), .br_pc(br_pc), .ext(ext),
        .redirect(redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 25'h1555555;
    endfunction

    // Memory model: samples the request mid-cycle, answers ack_dly cycles later.
    initial begin : responder
        bit            req_s;
        logic [AW-1:0] addr_s;
        logic [AW-1:0] pend_addr;
        int            pend;
        pend = 0;
        pend_addr = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            req_s  = (mem_req === 1'b1) && (rst_n === 1'b1);
            addr_s = mem_addr;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_word(pend_addr);
                end
            end
            if (req_s) begin
                if (ack_dly <= 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_word(addr_s);
                end else begin
                    pend = ack_dly - 1;
                    pend_addr = addr_s;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until an instruction is presented; no checking here.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ins_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
            #1;
        end
        ok = (ins_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; halt = 1'b0; ins_ready = 1'b1;
        br_valid = 1'b1; branch = 1'b1; zero = 1'b1; br_pc = 25'h55; ext = '0;
        tick(); tick(); #1;
        n_vec++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL rst_ins_valid got=%b exp=0", ins_valid); end
        n_vec++; if (ins !== '0) begin n_err++; $display("FAIL rst_ins got=%h exp=0", ins); end
        n_vec++; if (ins_pc !== '0) begin n_err++; $display("FAIL rst_ins_pc got=%h exp=0", ins_pc); end
        n_vec++; if (mem_addr !== 25'h0) begin n_err++; $display("FAIL rst_pc got=%h exp=0", mem_addr); end
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL rst_redirect got=%b exp=0", redirect); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        br_valid = 1'b0; rst_n = 1'b1;
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL post_rst_first_cycle mem_req got=%b exp=0", mem_req); end
    endtask

    task automatic test_straight();
        int nreq = 0;
        int ndel = 0;
        int last_c = -1;
        exp_addr = 25'h0;
        ack_dly = 2;
        for (int c = 0; c < 16; c++) begin
            tick(); #1;
            if (c == 0) begin
                n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL first_req_second_cycle mem_req got=%b exp=1", mem_req); end
            end
            if (mem_req === 1'b1) begin
                n_vec++;
                if (mem_addr !== exp_addr) begin n_err++; $display("FAIL straight_addr got=%h exp=%h", mem_addr, exp_addr); end
                exp_q.push_back('{pc: exp_addr, ins: mem_word(exp_addr)});
                exp_addr = exp_addr + 25'd1;
                nreq++;
            end
            if (ins_valid === 1'b1 && ins_ready === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL straight_deliver unexpected ins_pc=%h, queue empty", ins_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (ins !== e.ins || ins_pc !== e.pc) begin
                        n_err++; $display("FAIL straight_data got ins=%h pc=%h exp ins=%h pc=%h", ins, ins_pc, e.ins, e.pc);
                    end
                end
                if (last_c >= 0) begin
                    n_vec++; if (c - last_c != 4) begin n_err++; $display("FAIL straight_spacing got=%0d exp=4", c - last_c); end
                end
                last_c = c;
                ndel++;
            end
        end
        n_vec++; if (nreq != 4) begin n_err++; $display("FAIL straight_req_count got=%0d exp=4", nreq); end
        n_vec++; if (ndel != 4) begin n_err++; $display("FAIL straight_ins_count got=%0d exp=4", ndel); end
    endtask

    task automatic test_backpressure();
        tick();
        ins_ready = 1'b0;
        #1;
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin n_err++; $display("FAIL bp_req got req=%b addr=%h exp req=1 addr=%h", mem_req, mem_addr, exp_addr); end
        exp_q.push_back('{pc: exp_addr, ins: mem_word(exp_addr)});
        wait_valid(got);
        n_vec++; if (!got) begin n_err++; $display("FAIL bp_timeout ins_valid=%b exp=1", ins_valid); end
        held_ins = ins;
        held_pc = ins_pc;
        for (int i = 0; i < 5; i++) begin
            br_valid = 1'b1; branch = i[0]; zero = ~i[0];
            br_pc = AW'($urandom); ext = AW'($urandom);
            tick(); #1;
            n_vec++;
            if (ins_valid !== 1'b1 || ins !== held_ins || ins_pc !== held_pc || mem_req !== 1'b0 || redirect !== 1'b0) begin
                n_err++; $display("FAIL bp_hold got v=%b ins=%h pc=%h req=%b redir=%b exp v=1 ins=%h pc=%h req=0 redir=0",
                                  ins_valid, ins, ins_pc, mem_req, redirect, held_ins, held_pc);
            end
        end
        br_valid = 1'b0;
        ins_ready = 1'b1;
        #1;
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL bp_deliver queue empty, exp one entry"); end
        else begin
            e = exp_q.pop_front();
            if (ins !== e.ins || ins_pc !== e.pc) begin n_err++; $display("FAIL bp_data got ins=%h pc=%h exp ins=%h pc=%h", ins, ins_pc, e.ins, e.pc); end
        end
        tick(); #1;
        exp_addr = held_pc + 25'd1;
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin n_err++; $display("FAIL bp_next_req got req=%b addr=%h exp req=1 addr=%h", mem_req, mem_addr, exp_addr); end
        exp_q.push_back('{pc: exp_addr, ins: mem_word(exp_addr)});
    endtask

    task automatic test_halt();
        wait_valid(got);
        n_vec++;
        if (!got || exp_q.size() == 0) begin n_err++; $display("FAIL halt_deliver ins_valid=%b queued=%0d exp valid with entry", ins_valid, exp_q.size()); end
        else begin
            e = exp_q.pop_front();
            if (ins !== e.ins || ins_pc !== e.pc) begin n_err++; $display("FAIL halt_data got ins=%h pc=%h exp ins=%h pc=%h", ins, ins_pc, e.ins, e.pc); end
        end
        held_pc = e.pc;
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            n_vec++;
            if (mem_req !== 1'b0 || ins_valid !== 1'b0 || mem_addr !== held_pc + 25'd1) begin
                n_err++; $display("FAIL halt_idle got req=%b v=%b addr=%h exp req=0 v=0 addr=%h", mem_req, ins_valid, mem_addr, held_pc + 25'd1);
            end
        end
        halt = 1'b0;
        tick(); #1;
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== held_pc + 25'd1) begin n_err++; $display("FAIL halt_resume got req=%b addr=%h exp req=1 addr=%h", mem_req, mem_addr, held_pc + 25'd1); end
        halt = 1'b1;
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL halt_comb_req got=%b exp=0", mem_req); end
    endtask

    task automatic test_taken_wait();
        br_valid = 1'b1; branch = 1'b1; zero = 1'b1; br_pc = 25'h0F; ext = '0;
        tick();
        br_valid = 1'b0; halt = 1'b0; ack_dly = 3;
        #1;
        n_vec++; if (redirect !== 1'b1 || mem_addr !== 25'h10 || mem_req !== 1'b1) begin n_err++; $display("FAIL tw_setup got redir=%b addr=%h req=%b exp redir=1 addr=10 req=1", redirect, mem_addr, mem_req); end
        tick();
        br_valid = 1'b1; branch = 1'b1; zero = 1'b1; br_pc = 25'h08; ext = 25'h1FFFFFD;
        #1;
        n_vec++; if (redirect !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL tw_wait got redir=%b req=%b exp redir=0 req=0", redirect, mem_req); end
        tick();
        br_valid = 1'b0;
        #1;
        n_vec++; if (redirect !== 1'b1 || mem_addr !== 25'h06 || ins_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL tw_drain got redir=%b addr=%h v=%b req=%b exp redir=1 addr=06 v=0 req=0", redirect, mem_addr, ins_valid, mem_req);
        end
        ack_dly = 2;
        tick(); #1;
        n_vec++; if (ins_valid !== 1'b0 || mem_req !== 1'b0 || redirect !== 1'b0) begin n_err++; $display("FAIL tw_stale_ack got v=%b req=%b redir=%b exp all 0", ins_valid, mem_req, redirect); end
        tick(); #1;
        n_vec++; if (ins_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 25'h06 || redirect !== 1'b0) begin
            n_err++; $display("FAIL tw_refetch got v=%b req=%b addr=%h redir=%b exp v=0 req=1 addr=06 redir=0", ins_valid, mem_req, mem_addr, redirect);
        end
        exp_q.push_back('{pc: 25'h06, ins: mem_word(25'h06)});
        wait_valid(got);
        n_vec++;
        if (!got || exp_q.size() == 0) begin n_err++; $display("FAIL tw_deliver ins_valid=%b exp 1", ins_valid); end
        else begin
            e = exp_q.pop_front();
            if (ins !== e.ins || ins_pc !== e.pc) begin n_err++; $display("FAIL tw_data got ins=%h pc=%h exp ins=%h pc=%h", ins, ins_pc, e.ins, e.pc); end
        end
    endtask

    task automatic test_simultaneous();
        tick(); #1;
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 25'h07) begin n_err++; $display("FAIL sim_req got req=%b addr=%h exp req=1 addr=07", mem_req, mem_addr); end
        tick();
        tick();
        br_valid = 1'b1; branch = 1'b1; zero = 1'b1; br_pc = 25'h1FFFFFF; ext = '0;
        tick();
        br_valid = 1'b0;
        #1;
        n_vec++; if (ins_valid !== 1'b0 || mem_addr !== 25'h0 || mem_req !== 1'b1 || redirect !== 1'b1) begin
            n_err++; $display("FAIL sim_drop got v=%b addr=%h req=%b redir=%b exp v=0 addr=0 req=1 redir=1", ins_valid, mem_addr, mem_req, redirect);
        end
        exp_q.push_back('{pc: 25'h0, ins: mem_word(25'h0)});
        wait_valid(got);
        n_vec++;
        if (!got || exp_q.size() == 0) begin n_err++; $display("FAIL sim_deliver ins_valid=%b exp 1", ins_valid); end
        else begin
            e = exp_q.pop_front();
            if (ins !== e.ins || ins_pc !== e.pc) begin n_err++; $display("FAIL sim_data got ins=%h pc=%h exp ins=%h pc=%h", ins, ins_pc, e.ins, e.pc); end
        end
    endtask

    task automatic test_reset_mid_wait();
        tick(); #1;
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 25'h01) begin n_err++; $display("FAIL rmw_req got req=%b addr=%h exp req=1 addr=01", mem_req, mem_addr); end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_vec++; if (ins_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 25'h0 || ins !== '0) begin
            n_err++; $display("FAIL rmw_after_rst got v=%b req=%b addr=%h ins=%h exp v=0 req=0 addr=0 ins=0", ins_valid, mem_req, mem_addr, ins);
        end
        tick(); #1;
        n_vec++; if (ins_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 25'h0) begin
            n_err++; $display("FAIL rmw_first_req got v=%b req=%b addr=%h exp v=0 req=1 addr=0", ins_valid, mem_req, mem_addr);
        end
        exp_q.push_back('{pc: 25'h0, ins: mem_word(25'h0)});
        wait_valid(got);
        n_vec++;
        if (!got || exp_q.size() == 0) begin n_err++; $display("FAIL rmw_deliver ins_valid=%b exp 1", ins_valid); end
        else begin
            e = exp_q.pop_front();
            if (ins !== e.ins || ins_pc !== e.pc) begin n_err++; $display("FAIL rmw_data got ins=%h pc=%h exp ins=%h pc=%h", ins, ins_pc, e.ins, e.pc); end
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_backpressure();
        test_halt();
        test_taken_wait();
        test_simultaneous();
        test_reset_mid_wait();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL leftover_expected got=%0d exp=0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
